// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the push-button conditioner.
// The PRESS_TIMER_EN build uses HOLD_W/HOLD_MAX for the press-duration timer.
package bj_button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int              HOLD_W   = 12;
  localparam logic [HOLD_W-1:0] HOLD_MAX = 12'd4095;

endpackage

// File: rtl/button_conditioner_sync.sv
// Multi-flop synchronizer for an asynchronous input, with a selectable reset level.
// The reset level matches the button's idle level, so leaving reset produces no false edge.
module button_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= {STAGES{rst_val_i}};
    end else begin
      sr_q <= {sr_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sr_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Debounces one raw push-button line into a clean level plus single-cycle edge pulses.
// Define PRESS_TIMER_EN to build the press-duration counter on o_HoldCount.
//
// state        | meaning
// RELEASED     | debounced level is idle, watching for a press
// PRESS_WAIT   | pressed level seen, counting stable cycles
// PRESSED      | debounced level is pressed, watching for a release
// RELEASE_WAIT | idle level seen, counting stable cycles
module button_conditioner
  import bj_button_pkg::*;
#(
  parameter int DEB_CYCLES  = 20,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              i_Reset,
  input  logic              i_Btn,
  output logic              o_Deb,
  output logic              o_PE,
  output logic              o_NE,
  output logic [HOLD_W-1:0] o_HoldCount
);

  localparam logic           IDLE     = (ACTIVE_LOW != 0);
  localparam int             CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s_btn;
  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             deb_q;
  logic             pe_q;
  logic             ne_q;

  button_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i     (clk),
    .rst_i     (i_Reset),
    .rst_val_i (IDLE),
    .d_i       (i_Btn),
    .q_o       (s_btn)
  );

  // Counter saturates at CNT_DONE because reaching it always leaves the WAIT state.
  always_ff @(posedge clk) begin
    if (i_Reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      deb_q   <= IDLE;
      pe_q    <= 1'b0;
      ne_q    <= 1'b0;
    end else begin
      pe_q <= 1'b0;
      ne_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (s_btn != IDLE) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (s_btn == IDLE) begin
            state_q <= RELEASED;
          end else if (cnt_q == CNT_DONE) begin
            state_q <= PRESSED;
            deb_q   <= ~IDLE;
            pe_q    <= ~IDLE;
            ne_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (s_btn == IDLE) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (s_btn != IDLE) begin
            state_q <= PRESSED;
          end else if (cnt_q == CNT_DONE) begin
            state_q <= RELEASED;
            deb_q   <= IDLE;
            pe_q    <= IDLE;
            ne_q    <= ~IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= RELEASED;
      endcase
    end
  end

  assign o_Deb = deb_q;
  assign o_PE  = pe_q;
  assign o_NE  = ne_q;

`ifdef PRESS_TIMER_EN
  logic              press_acc;
  logic [HOLD_W-1:0] hold_q;

  assign press_acc = (state_q == PRESS_WAIT) && (s_btn != IDLE) && (cnt_q == CNT_DONE);

  // The release-accept edge still counts: deb_q is pressed going into it.
  always_ff @(posedge clk) begin
    if (i_Reset) begin
      hold_q <= '0;
    end else if (press_acc) begin
      hold_q <= '0;
    end else if ((deb_q != IDLE) && (hold_q != HOLD_MAX)) begin
      hold_q <= hold_q + HOLD_W'(1);
    end
  end

  assign o_HoldCount = hold_q;
`else
  assign o_HoldCount = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: run-length reference model plus directed latency checks.
module tb_button_conditioner;
  import bj_button_pkg::*;

  localparam int   DEB  = 20;
  localparam int   SYNC = 2;
  localparam logic IDLE = 1'b1;

  logic              clk = 1'b0;
  logic              i_Reset;
  logic              i_Btn;
  logic              o_Deb;
  logic              o_PE;
  logic              o_NE;
  logic [HOLD_W-1:0] o_HoldCount;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEB_CYCLES  (DEB),
    .SYNC_STAGES (SYNC),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk         (clk),
    .i_Reset     (i_Reset),
    .i_Btn       (i_Btn),
    .o_Deb       (o_Deb),
    .o_PE        (o_PE),
    .o_NE        (o_NE),
    .o_HoldCount (o_HoldCount)
  );

  // Reference: a level flips once DEB+1 consecutive synchronized samples disagree with it.
  int   edge_n = 0;
  logic hist [SYNC];
  logic m_deb, m_pe, m_ne;
  int   m_run, m_hold;

  always @(posedge clk) begin
    logic s;
    edge_n++;
    if (i_Reset) begin
      for (int i = 0; i < SYNC; i++) hist[i] = IDLE;
      m_deb = IDLE; m_pe = 1'b0; m_ne = 1'b0; m_run = 0; m_hold = 0;
    end else begin
      s = hist[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = i_Btn;
      m_pe = 1'b0; m_ne = 1'b0;
      if (m_deb != IDLE) m_hold = (m_hold < 4095) ? m_hold + 1 : 4095;
      if (s != m_deb) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_deb = s; m_pe = s; m_ne = ~s; m_run = 0;
          if (s != IDLE) m_hold = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at edge %0d", nm, act, exp, edge_n);
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      check("deb_model", 32'(o_Deb), 32'(m_deb));
      check("pe_model",  32'(o_PE),  32'(m_pe));
      check("ne_model",  32'(o_NE),  32'(m_ne));
`ifdef PRESS_TIMER_EN
      check("hold_model", 32'(o_HoldCount), 32'(m_hold));
`else
      check("hold_tied0", 32'(o_HoldCount), 32'd0);
`endif
    end
  endtask

  task automatic run_watch(input int n, output int pe_n, output int ne_n, output int chg,
                           output logic [HOLD_W-1:0] hold_chg);
    logic prev;
    pe_n = 0; ne_n = 0; chg = -1; hold_chg = '0;
    for (int i = 0; i < n; i++) begin
      prev = o_Deb;
      tick();
      if (o_PE) pe_n++;
      if (o_NE) ne_n++;
      if (o_Deb !== prev && chg < 0) begin
        chg = edge_n;
        hold_chg = o_HoldCount;
      end
    end
  endtask

  int pe_n, ne_n, chg, start;
  logic [HOLD_W-1:0] hold_chg;

  initial begin
    i_Reset = 1'b1;
    i_Btn   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_deb",  32'(o_Deb), 32'd1);
    check("rst_pe",   32'(o_PE),  32'd0);
    check("rst_ne",   32'(o_NE),  32'd0);
    check("rst_hold", 32'(o_HoldCount), 32'd0);
    chk_en  = 1'b1;
    i_Reset = 1'b0;
    repeat (5) tick();

    // Clean press
    start = edge_n; i_Btn = 1'b0;
    run_watch(50, pe_n, ne_n, chg, hold_chg);
    check("press_latency", 32'(chg - (start + 1)), 32'd22);
    check("press_ne_cnt",  32'(ne_n), 32'd1);
    check("press_pe_cnt",  32'(pe_n), 32'd0);

    // Release, then bounce: short press burst must be rejected
    i_Btn = 1'b1;
    run_watch(40, pe_n, ne_n, chg, hold_chg);
    check("rel1_pe_cnt", 32'(pe_n), 32'd1);
    i_Btn = 1'b0;
    run_watch(19, pe_n, ne_n, chg, hold_chg);
    check("bounce_a_chg", 32'(chg), 32'hFFFF_FFFF);
    i_Btn = 1'b1;
    run_watch(5, pe_n, ne_n, chg, hold_chg);
    check("bounce_b_chg", 32'(chg), 32'hFFFF_FFFF);
    start = edge_n; i_Btn = 1'b0;
    run_watch(30, pe_n, ne_n, chg, hold_chg);
    check("bounce_latency", 32'(chg - (start + 1)), 32'd22);
    check("bounce_ne_cnt",  32'(ne_n), 32'd1);

    // Release from pressed
    start = edge_n; i_Btn = 1'b1;
    run_watch(30, pe_n, ne_n, chg, hold_chg);
    check("release_latency", 32'(chg - (start + 1)), 32'd22);
    check("release_pe_cnt",  32'(pe_n), 32'd1);
    check("release_ne_cnt",  32'(ne_n), 32'd0);

    // Toggle every cycle: no activity
    pe_n = 0; ne_n = 0;
    begin
      int tp, tn, tc;
      tp = 0; tn = 0; tc = -1;
      for (int i = 0; i < 200; i++) begin
        i_Btn = ~i_Btn;
        run_watch(1, pe_n, ne_n, chg, hold_chg);
        tp += pe_n; tn += ne_n;
        if (chg >= 0) tc = chg;
      end
      check("toggle_pulses", 32'(tp + tn), 32'd0);
      check("toggle_chg",    32'(tc), 32'hFFFF_FFFF);
    end

    // Reset while pressed; held button is re-debounced afterwards
    i_Btn = 1'b0;
    run_watch(40, pe_n, ne_n, chg, hold_chg);
    check("pre_rst_deb", 32'(o_Deb), 32'd0);
    i_Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("in_rst_deb",   32'(o_Deb), 32'd1);
      check("in_rst_pulse", 32'(o_PE | o_NE), 32'd0);
    end
    start = edge_n; i_Reset = 1'b0;
    run_watch(30, pe_n, ne_n, chg, hold_chg);
    check("post_rst_latency", 32'(chg - (start + 1)), 32'd22);
    check("post_rst_ne_cnt",  32'(ne_n), 32'd1);
    check("post_rst_pe_cnt",  32'(pe_n), 32'd0);

`ifdef PRESS_TIMER_EN
    i_Btn = 1'b1;
    run_watch(40, pe_n, ne_n, chg, hold_chg);
    i_Btn = 1'b0;
    run_watch(100, pe_n, ne_n, chg, hold_chg);
    i_Btn = 1'b1;
    run_watch(40, pe_n, ne_n, chg, hold_chg);
    check("hold_p100", 32'(o_HoldCount), 32'd100);
    i_Btn = 1'b0;
    run_watch(5000, pe_n, ne_n, chg, hold_chg);
    i_Btn = 1'b1;
    run_watch(40, pe_n, ne_n, chg, hold_chg);
    check("hold_sat", 32'(o_HoldCount), 32'd4095);
    i_Btn = 1'b0;
    run_watch(30, pe_n, ne_n, chg, hold_chg);
    check("hold_clear", 32'(hold_chg), 32'd0);
`endif

    // Randomized runs with occasional resets, checked every cycle against the model
    for (int seg = 0; seg < 200; seg++) begin
      if ($urandom_range(0, 24) == 0) begin
        i_Reset = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        i_Reset = 1'b0;
      end
      i_Btn = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 40)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Receive side of the player push-button interface: takes one raw, asynchronous, bouncing button line and produces a clean debounced level plus single-cycle edge pulses for the game FSMs.
- Three instances sit at the top of BlackJack, one each for Reset, Hit and Stay, in the clk_PLL domain.
- Optional press-duration timer provides the hold count the shuffler uses as its seed.

Parameters:
- DEB_CYCLES, 20, consecutive stable clock cycles needed to accept a level change (10 ms at 2 kHz). Legal range 1..255.
- SYNC_STAGES, 2, synchronizer flop count. Minimum 2.
- ACTIVE_LOW, 1, 1 = button idles high and pulls low when pressed; 0 = idles low.

Ports:
- clk  input  1  clock, clk_PLL domain.
- i_Reset  input  1  synchronous, active-high reset.
- i_Btn  input  1  raw button line, asynchronous to clk.
- o_Deb  output  1  debounced level, same polarity as i_Btn.
- o_PE  output  1  one-cycle pulse on each rising edge of o_Deb.
- o_NE  output  1  one-cycle pulse on each falling edge of o_Deb.
- o_HoldCount  output  12  cycles o_Deb spent at the pressed level. Functional only with PRESS_TIMER_EN.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - Synchronizer flops = IDLE (IDLE = ACTIVE_LOW ? 1 : 0).
  - State = RELEASED, counter = 0.
  - o_Deb = IDLE, o_PE = 0, o_NE = 0, o_HoldCount = 0.
- Synchronizer: SYNC_STAGES-flop chain. s_Btn is its last stage.
- FSM, 4 states:
  - RELEASED: if s_Btn != IDLE, go to PRESS_WAIT and set cnt = 1. Otherwise stay.
  - PRESS_WAIT: if s_Btn == IDLE, return to RELEASED (glitch rejected, no output change). Else if cnt == DEB_CYCLES, go to PRESSED, set o_Deb = !IDLE and pulse the press edge. Else cnt++.
  - PRESSED: mirror of RELEASED, toward RELEASE_WAIT.
  - RELEASE_WAIT: mirror of PRESS_WAIT. Accepting the change sets o_Deb = IDLE and pulses the release edge.
  - DEB_CYCLES = 1: the change is accepted on the first cycle it is seen in the WAIT state.
- Latency: o_Deb changes exactly SYNC_STAGES + DEB_CYCLES clock edges after the first edge that samples a stable new level on i_Btn. Defaults give 22.
- Edge pulses:
  - o_PE/o_NE are asserted in the same cycle o_Deb changes, for exactly one cycle.
  - They are never both high. Neither is asserted without an o_Deb change.
  - With ACTIVE_LOW = 1, press gives o_NE and release gives o_PE.
- Counter width: clog2(DEB_CYCLES+1). It never wraps, because it stops at DEB_CYCLES.
- Reset mid-operation:
  - State returns to RELEASED in any state, with no pulse emitted during or on exit from reset.
  - A button still held after reset is re-debounced and produces a fresh press pulse after the full latency.
- Input toggling every cycle: o_Deb never changes.

Optional Feature:
- Macro: PRESS_TIMER_EN.
- Defined:
  - On the press-accept edge, o_HoldCount loads 0.
  - On every later edge with o_Deb at the pressed level, including the release-accept edge, it increments, saturating at 4095.
  - Between the release-accept edge and the next press-accept it holds its value.
  - A raw press lasting P cycles therefore yields o_HoldCount = min(P, 4095).
- Undefined: o_HoldCount is tied to 0 and no timer flops are built.

Decomposition:
- Package bj_button_pkg holds:
  - the 2-bit state encoding: RELEASED = 0, PRESS_WAIT = 1, PRESSED = 2, RELEASE_WAIT = 3;
  - HOLD_W = 12 and HOLD_MAX = 4095.
- Natural sub-module: button_sync, a parameterized SYNC_STAGES flop chain with a reset value input.

Test Plan:
All scenarios use defaults: DEB_CYCLES = 20, SYNC_STAGES = 2, ACTIVE_LOW = 1.
1. i_Reset = 1 for 3 cycles with i_Btn = 1 -> o_Deb = 1, o_PE = o_NE = 0, o_HoldCount = 0.
2. i_Btn 1->0 held 50 cycles -> o_Deb falls exactly 22 edges after the first sampling edge; o_NE high for 1 cycle in that cycle; o_PE stays 0.
3. Bounce: i_Btn = 0 for 19 cycles, then 1 for 5, then 0 for 30 -> no change on the first burst; o_Deb falls 22 edges into the final burst; exactly one o_NE pulse.
4. From pressed, i_Btn = 1 for 30 cycles -> o_Deb rises 22 edges later with a single o_PE pulse. Alternating i_Btn every cycle for 200 cycles -> no output activity.
5. Held press with i_Reset = 1 for 2 cycles while PRESSED -> o_Deb = 1 during reset with no pulse; after reset, o_NE again 22 edges after release of reset.
6. PRESS_TIMER_EN: raw press of P = 100 cycles -> o_HoldCount = 100 after o_PE. P = 5000 -> 4095. A later press clears the count to 0 at its press-accept edge.
